// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the interconnect bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOwn,
    StTurn
  } arb_state_e;

  localparam logic [1:0] SRC_AES   = 2'b00;
  localparam logic [1:0] SRC_SHA   = 2'b01;
  localparam logic [1:0] SRC_SPARE = 2'b10;
  localparam logic [1:0] SRC_CTRL  = 2'b11;

  localparam int unsigned DEFAULT_N_REQ     = 4;
  localparam int unsigned DEFAULT_MAX_BEATS = 8;
  localparam int unsigned DEFAULT_TIMEOUT   = 16;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first active request after `last`, wrapping.
module rr_select #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IdW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IdW-1:0]   last,
  output logic [N_REQ-1:0] pick,
  output logic [IdW-1:0]   pick_id,
  output logic             any
);

  always_comb begin
    int unsigned idx;
    logic [IdW-1:0] idx_id;
    logic found;
    pick    = '0;
    pick_id = '0;
    found   = 1'b0;
    idx     = 0;
    idx_id  = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx    = ({{(32 - IdW){1'b0}}, last} + off) % N_REQ;
      idx_id = IdW'(idx);
      if (!found && req[idx_id]) begin
        found        = 1'b1;
        pick[idx_id] = 1'b1;
        pick_id      = idx_id;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner selection for the shared data bus with beat limit, timeout
// and a one-cycle turnaround between owners.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = DEFAULT_N_REQ,
  parameter int unsigned MAX_BEATS = DEFAULT_MAX_BEATS,
  parameter int unsigned TIMEOUT   = DEFAULT_TIMEOUT,
  localparam int unsigned IdW      = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             bus_valid,
  input  logic             ack,
  output logic [N_REQ-1:0] grant,
  output logic [IdW-1:0]   grant_id,
  output logic             grant_valid,
  output logic             timeout_err
);

  localparam int unsigned BeatW = $clog2(MAX_BEATS + 1);
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IdW-1:0]   grant_id_q, grant_id_d;
  logic [IdW-1:0]   last_q, last_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             timeout_err_q, timeout_err_d;

  logic [N_REQ-1:0] pick;
  logic [IdW-1:0]   pick_id;
  logic             any_req;
  logic             beat_hit, idle_hit, owner_req;

  rr_select #(
    .N_REQ(N_REQ)
  ) u_rr_select (
    .req    (req),
    .last   (last_q),
    .pick   (pick),
    .pick_id(pick_id),
    .any    (any_req)
  );

  // Limits are hit by the cycle that would bring the count to its bound.
  assign beat_hit  = bus_valid && (beat_q == BeatW'(MAX_BEATS - 1));
  assign idle_hit  = !bus_valid && (idle_q == IdleW'(TIMEOUT - 1));
  assign owner_req = req[grant_id_q];

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    last_d        = last_q;
    beat_d        = beat_q;
    idle_d        = idle_q;
    timeout_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d    = StOwn;
          grant_d    = pick;
          grant_id_d = pick_id;
          last_d     = pick_id;
        end
      end
      StOwn: begin
        if (bus_valid) begin
          beat_d = beat_q + BeatW'(1);
          idle_d = '0;
        end else begin
          idle_d = idle_q + IdleW'(1);
        end
        if (ack || beat_hit || !owner_req || idle_hit) begin
          state_d       = StTurn;
          grant_d       = '0;
          grant_id_d    = '0;
          beat_d        = '0;
          idle_d        = '0;
          timeout_err_d = !ack && owner_req && idle_hit;
        end
      end
      StTurn: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      grant_id_q    <= '0;
      last_q        <= IdW'(N_REQ - 1);
      beat_q        <= '0;
      idle_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      last_q        <= last_d;
      beat_q        <= beat_d;
      idle_q        <= idle_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = |grant_q;
  assign timeout_err = timeout_err_q;

endmodule
